// File: rtl/cpu_sequencer_if.sv
// Instruction-memory and datapath bus between the sequencer and its neighbours.
//   imem_addr / imem_rd_en : sequencer -> instruction memory (synchronous read)
//   imem_rdata             : instruction memory -> sequencer, valid the cycle after imem_rd_en
//   instr / instr_valid    : sequencer -> datapath, one-cycle issue strobe
//   result                 : datapath -> sequencer, combinational ALU result for instr
interface cpu_sequencer_if #(
    parameter int unsigned PC_WIDTH = 4
) ();
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_rd_en;
    logic [7:0]          imem_rdata;
    logic [7:0]          instr;
    logic                instr_valid;
    logic [7:0]          result;

    // Sequencer side
    modport master (
        output imem_addr,
        output imem_rd_en,
        input  imem_rdata,
        output instr,
        output instr_valid,
        input  result
    );

    // Memory / datapath side
    modport slave (
        input  imem_addr,
        input  imem_rd_en,
        output imem_rdata,
        input  instr,
        input  instr_valid,
        output result
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU datapath.
// Walks pc through a synchronous instruction memory, issues one instruction at a
// time with a one-cycle instr_valid strobe, captures the ALU result, and handles
// HALT and JUMP internally.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   start, abort         : begin a run at pc 0 / force IDLE (abort wins)
//   bus (master)         : imem_addr, imem_rd_en, imem_rdata, instr, instr_valid, result
//   last_result          : result captured at the end of the latest EXEC
//   pc, instr_count      : program counter, issued-instruction count for this run
//   busy, done, timeout  : status (FETCH/DECODE/EXEC, DONE, budget exhausted)
module cpu_sequencer #(
    parameter int unsigned PC_WIDTH  = 4,
    parameter int unsigned MAX_INSTR = 200,
    parameter logic [3:0]  HALT_OP   = 4'hF,
    parameter logic [3:0]  JUMP_OP   = 4'hE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    cpu_sequencer_if.master     bus,
    output logic [7:0]          last_result,
    output logic [PC_WIDTH-1:0] pc,
    output logic [7:0]          instr_count,
    output logic                busy,
    output logic                done,
    output logic                timeout
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [7:0] MAX_COUNT = 8'(MAX_INSTR);

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic [7:0]          count_nxt;
    logic [7:0]          count_inc;
    logic [7:0]          last_result_nxt;
    logic [7:0]          ir;
    logic [7:0]          ir_nxt;
    logic                timeout_nxt;
    logic [3:0]          opcode;
    logic                instr_valid_q;
    logic                imem_rd_en_q;

    assign opcode    = bus.imem_rdata[7:4];
    assign count_inc = instr_count + 8'd1;

    // Memory address is the program counter itself; instr is forced to 0 off-strobe.
    assign bus.imem_addr   = pc;
    assign bus.imem_rd_en  = imem_rd_en_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_valid_q ? ir : 8'h00;

    // Next-state and next-value logic.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        count_nxt       = instr_count;
        last_result_nxt = last_result;
        ir_nxt          = ir;
        timeout_nxt     = timeout;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_nxt      = '0;
                    count_nxt   = 8'd0;
                    timeout_nxt = 1'b0;
                    state_nxt   = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == HALT_OP) begin
                    // pc stays on the HALT word
                    timeout_nxt = 1'b0;
                    state_nxt   = S_DONE;
                end else if (opcode == JUMP_OP) begin
                    pc_nxt    = bus.imem_rdata[PC_WIDTH-1:0];
                    state_nxt = S_FETCH;
                end else begin
                    ir_nxt    = bus.imem_rdata;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                last_result_nxt = bus.result;
                count_nxt       = count_inc;
                pc_nxt          = PC_WIDTH'(pc + 1'b1);
                if (count_inc == MAX_COUNT) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_DONE;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything: go idle, keep the architectural values.
        if (abort) begin
            state_nxt       = S_IDLE;
            pc_nxt          = pc;
            count_nxt       = instr_count;
            last_result_nxt = last_result;
            ir_nxt          = ir;
            timeout_nxt     = 1'b0;
        end
    end

    // State and datapath registers; status outputs are registered from the next state
    // so they line up exactly with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            pc            <= '0;
            instr_count   <= 8'd0;
            last_result   <= 8'd0;
            ir            <= 8'd0;
            timeout       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            instr_valid_q <= 1'b0;
            imem_rd_en_q  <= 1'b0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            instr_count   <= count_nxt;
            last_result   <= last_result_nxt;
            ir            <= ir_nxt;
            timeout       <= timeout_nxt;
            busy          <= (state_nxt == S_FETCH) || (state_nxt == S_DECODE) ||
                             (state_nxt == S_EXEC);
            done          <= (state_nxt == S_DONE);
            instr_valid_q <= (state_nxt == S_EXEC);
            imem_rd_en_q  <= (state_nxt == S_FETCH);
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a synchronous program memory, a stub ALU, and
// scoreboards of expected memory addresses and issued instructions (with issue cycle).
module tb_cpu_sequencer;

    localparam int unsigned PW = 4;

    typedef struct {
        logic [7:0] instr;
        int         rel;
    } issue_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [7:0]    last_result;
    logic [PW-1:0] pc;
    logic [7:0]    instr_count;
    logic          busy;
    logic          done;
    logic          timeout;

    logic [7:0]    mem [16];
    int            cyc;
    int            t_start;
    int            n_cmp;
    int            n_err;

    logic [PW-1:0] exp_addr [$];
    issue_t        exp_iss  [$];

    cpu_sequencer_if #(.PC_WIDTH(PW)) bus ();

    cpu_sequencer #(
        .PC_WIDTH (PW),
        .MAX_INSTR(3),
        .HALT_OP  (4'hF),
        .JUMP_OP  (4'hE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .last_result(last_result),
        .pc         (pc),
        .instr_count(instr_count),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout)
    );

    function automatic logic [7:0] alu(input logic [7:0] i);
        return {i[3:0], i[7:4]} + 8'h03;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous instruction memory and stub datapath.
    always @(posedge clk) if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];
    assign bus.result = alu(bus.instr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every read and every issue must match the next expected entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.imem_rd_en) begin
                n_cmp++;
                assert (exp_addr.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_read: observed addr %0h expected none", bus.imem_addr);
                end
                if (exp_addr.size() != 0) chk("imem_addr", 32'(bus.imem_addr), 32'(exp_addr.pop_front()));
            end
            if (bus.instr_valid) begin
                n_cmp++;
                assert (exp_iss.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_issue: observed instr %0h expected none", bus.instr);
                end
                if (exp_iss.size() != 0) begin
                    issue_t e;
                    e = exp_iss.pop_front();
                    chk("instr", 32'(bus.instr), 32'(e.instr));
                    chk("issue_cycle", 32'(cyc - t_start), 32'(e.rel));
                end
            end else begin
                chk("instr_idle_zero", 32'(bus.instr), 32'h0);
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'hF0;
    endtask

    task automatic push_addrs(input int a0, input int a1, input int a2,
                              input int a3, input int a4, input int a5);
        int a [6];
        a = '{a0, a1, a2, a3, a4, a5};
        for (int i = 0; i < 6; i++) if (a[i] >= 0) exp_addr.push_back(PW'(a[i]));
    endtask

    task automatic push_issue(input logic [7:0] i, input int rel);
        issue_t e;
        e.instr = i;
        e.rel   = rel;
        exp_iss.push_back(e);
    endtask

    // Pulse start for one cycle; leaves the caller at the negedge after the start edge.
    task automatic start_run();
        start   = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int exp_rel);
        int k;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(done), 32'h1);
        chk("done_cycle", 32'(cyc - t_start), 32'(exp_rel));
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_addr_q_empty"}, 32'(exp_addr.size()), 32'h0);
        chk({tag, "_issue_q_empty"}, 32'(exp_iss.size()), 32'h0);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        cyc     = 0;
        t_start = 0;
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        clear_mem();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_count", 32'(instr_count), 32'h0);
        chk("rst_last_result", 32'(last_result), 32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_rd_en", 32'(bus.imem_rd_en), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Straight line: two ALU instructions then HALT
        clear_mem();
        mem[0] = 8'h14; mem[1] = 8'h25; mem[2] = 8'hF0;
        push_addrs(0, 1, 2, -1, -1, -1);
        push_issue(8'h14, 3);
        push_issue(8'h25, 6);
        start_run();
        chk("sl_busy", 32'(busy), 32'h1);
        wait_done(9);
        chk("sl_count", 32'(instr_count), 32'h2);
        chk("sl_pc", 32'(pc), 32'h2);
        chk("sl_last_result", 32'(last_result), 32'(alu(8'h25)));
        chk("sl_timeout", 32'(timeout), 32'h0);
        chk("sl_busy_done", 32'(busy), 32'h0);
        check_drained("sl");

        // Jump over mem[2..4]
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'hE5; mem[5] = 8'hF0;
        push_addrs(0, 1, 5, -1, -1, -1);
        push_issue(8'h11, 3);
        start_run();
        wait_done(8);
        chk("jmp_pc", 32'(pc), 32'h5);
        chk("jmp_count", 32'(instr_count), 32'h1);
        chk("jmp_last_result", 32'(last_result), 32'(alu(8'h11)));
        check_drained("jmp");

        // Budget exhaustion on a two-word loop (MAX_INSTR = 3)
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'hE0;
        push_addrs(0, 1, 0, 1, 0, -1);
        push_issue(8'h11, 3);
        push_issue(8'h11, 8);
        push_issue(8'h11, 13);
        start_run();
        wait_done(14);
        chk("to_timeout", 32'(timeout), 32'h1);
        chk("to_count", 32'(instr_count), 32'h3);
        chk("to_pc", 32'(pc), 32'h1);
        check_drained("to");

        // Restart from DONE clears timeout; start pulses while busy are ignored
        clear_mem();
        mem[0] = 8'h14; mem[1] = 8'h25; mem[2] = 8'hF0;
        push_addrs(0, 1, 2, -1, -1, -1);
        push_issue(8'h14, 3);
        push_issue(8'h25, 6);
        start_run();
        chk("rs_timeout_cleared", 32'(timeout), 32'h0);
        chk("rs_done_cleared", 32'(done), 32'h0);
        start = 1'b1;                  // during FETCH
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;  // during EXEC
        @(negedge clk); start = 1'b0;
        wait_done(9);
        chk("ign_count", 32'(instr_count), 32'h2);
        chk("ign_pc", 32'(pc), 32'h2);
        chk("ign_last_result", 32'(last_result), 32'(alu(8'h25)));
        check_drained("ign");

        // PC wrap: jump to 15, execute, pc wraps to 0, repeat until budget
        clear_mem();
        mem[0] = 8'hEF; mem[15] = 8'h12;
        push_addrs(0, 15, 0, 15, 0, 15);
        push_issue(8'h12, 5);
        push_issue(8'h12, 10);
        push_issue(8'h12, 15);
        start_run();
        wait_done(16);
        chk("wrap_pc", 32'(pc), 32'h0);
        chk("wrap_count", 32'(instr_count), 32'h3);
        chk("wrap_timeout", 32'(timeout), 32'h1);
        check_drained("wrap");

        // Abort during DECODE, with start also asserted (abort wins)
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'hF0;
        push_addrs(0, -1, -1, -1, -1, -1);
        start_run();
        @(negedge clk);                // now in DECODE
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("ab_busy", 32'(busy), 32'h0);
        chk("ab_done", 32'(done), 32'h0);
        chk("ab_timeout", 32'(timeout), 32'h0);
        chk("ab_pc_held", 32'(pc), 32'h0);
        chk("ab_count_held", 32'(instr_count), 32'h0);
        repeat (2) @(negedge clk);
        chk("ab_still_idle", 32'(busy), 32'h0);
        check_drained("ab");
        push_addrs(0, 1, -1, -1, -1, -1);
        push_issue(8'h11, 3);
        start_run();
        wait_done(6);
        chk("ab_rerun_count", 32'(instr_count), 32'h1);
        chk("ab_rerun_pc", 32'(pc), 32'h1);
        check_drained("ab_rerun");

        // Asynchronous reset in the middle of EXEC
        push_addrs(0, -1, -1, -1, -1, -1);
        push_issue(8'h11, 3);
        start_run();
        repeat (2) @(negedge clk);     // EXEC
        #1 reset = 1'b1;
        #1;
        chk("ar_valid", 32'(bus.instr_valid), 32'h0);
        chk("ar_instr", 32'(bus.instr), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_last_result", 32'(last_result), 32'h0);
        chk("ar_pc", 32'(pc), 32'h0);
        chk("ar_count", 32'(instr_count), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("ar_idle_after", 32'(busy), 32'h0);
        check_drained("ar");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
